rxfis_sched: RTL

Frame-level scheduler between the two receive buffers and the receive DMA, in the `sys_clk` domain. It drains complete FISes from the data FIFO (`rxll_fifo` path) and from the non-data-register FIFO (`ififo` path) into one registered word stream toward `rxdma`. It alternates between the sources round-robin at frame boundaries, enforces a maximum frame length and reports per-frame status.

---
 rtl/rxfis_pkg.sv | 32 +++
 rtl/rxfis_oreg.sv | 33 +++
 rtl/rxfis_sched.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/rxfis_pkg.sv
// Shared definitions for the receive FIS scheduler: word layout, flag bits,
// state and source encodings.
package rxfis_pkg;

  localparam int unsigned C_MAX_WORDS = 2049;
  localparam int unsigned C_DW        = 36;
  localparam int unsigned CNT_W       = 12;
  localparam int unsigned FRM_W       = 16;
  localparam int unsigned OVR_W       = 8;

  localparam int unsigned SOF = 32;
  localparam int unsigned EOF = 33;
  localparam int unsigned ERR = 34;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_XFER  = 3'd1,
    ST_DRAIN = 3'd2
  } state_t;

  typedef enum logic {
    SRC_DATA = 1'b0,
    SRC_NDR  = 1'b1
  } src_t;

  // Output register payload: the word plus the FIFO it came from.
  typedef struct packed {
    src_t            src;
    logic [C_DW-1:0] word;
  } oword_t;

endpackage

// File: rtl/rxfis_oreg.sv
// Single-entry output holding register toward rxdma; a load may coincide
// with the acceptance of the word currently held.
module rxfis_oreg
  import rxfis_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   flush,
  input  logic   load,
  input  oword_t ld_data,
  input  logic   ready,
  output logic   valid,
  output oword_t data,
  output logic   accept_c
);

  assign accept_c = valid & ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= ld_data;
    end else if (accept_c) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/rxfis_sched.sv
// Round-robin frame scheduler draining the data and NDR receive FIFOs into a
// single registered word stream toward rxdma, with frame-length enforcement.
module rxfis_sched
  import rxfis_pkg::*;
(
  input  logic            sys_clk,
  input  logic            sys_rst,
  input  logic [C_DW-1:0] rxll2rxdma_rd_do,
  input  logic            rxll2rxdma_rd_empty,
  input  logic            rxll2rxdma_rd_eof_rdy,
  output logic            rxfis2rxll_rd_en,
  input  logic [C_DW-1:0] ififo2rxdma_ndr_rd_do,
  input  logic            ififo2port_empty,
  output logic            rxfis2ififo_ndr_rd_en,
  output logic [C_DW-1:0] rxfis2rxdma_do,
  output logic            rxfis2rxdma_src,
  output logic            rxfis2rxdma_valid,
  input  logic            rxdma2rxfis_ready,
  input  logic            port2rxfis_flush,
  output logic            rxfis2port_done,
  output logic            rxfis2port_err,
  output logic [31:0]     rxfis2dbg
);

  state_t            state, state_nxt;
  src_t              src, src_nxt, last, last_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt, cnt_inc_c;
  logic [FRM_W-1:0]  frames;
  logic [OVR_W-1:0]  overruns;
  logic              ferr;
  logic              pop_c, load_c, ovr_c, done_c;
  logic              room_c, sel_empty_c, accept_c, oreg_valid;
  logic [C_DW-1:0]   sel_word_c;
  oword_t            ld_word_c, oreg_q;

  assign sel_empty_c = (src == SRC_NDR) ? ififo2port_empty : rxll2rxdma_rd_empty;
  assign sel_word_c  = (src == SRC_NDR) ? ififo2rxdma_ndr_rd_do : rxll2rxdma_rd_do;
  assign room_c      = !oreg_valid || accept_c;
  assign cnt_inc_c   = cnt + CNT_W'(1);
  assign done_c      = accept_c && oreg_q.word[EOF] && !port2rxfis_flush && !sys_rst;

  // Next-state, pop and load decisions.
  always_comb begin
    state_nxt      = state;
    src_nxt        = src;
    last_nxt       = last;
    cnt_nxt        = cnt;
    pop_c          = 1'b0;
    load_c         = 1'b0;
    ovr_c          = 1'b0;
    ld_word_c.src  = src;
    ld_word_c.word = sel_word_c;
    case (state)
      ST_IDLE: begin
        if (room_c && (rxll2rxdma_rd_eof_rdy || !ififo2port_empty)) begin
          if (rxll2rxdma_rd_eof_rdy && !ififo2port_empty)
            src_nxt = (last == SRC_NDR) ? SRC_DATA : SRC_NDR;
          else
            src_nxt = rxll2rxdma_rd_eof_rdy ? SRC_DATA : SRC_NDR;
          cnt_nxt   = '0;
          state_nxt = ST_XFER;
        end
      end
      ST_XFER: begin
        if (oreg_valid && oreg_q.word[EOF]) begin
          if (accept_c) begin
            state_nxt = ST_IDLE;
            last_nxt  = src;
          end
        end else if (!sel_empty_c && room_c) begin
          pop_c   = 1'b1;
          load_c  = 1'b1;
          cnt_nxt = cnt_inc_c;
          if (cnt == '0 && !sel_word_c[SOF])
            ld_word_c.word[ERR] = 1'b1;
          // Frame too long: terminate it here and discard the remainder.
          if (!sel_word_c[EOF] && cnt_inc_c == CNT_W'(C_MAX_WORDS)) begin
            ld_word_c.word[EOF] = 1'b1;
            ld_word_c.word[ERR] = 1'b1;
            ovr_c               = 1'b1;
            state_nxt           = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (!sel_empty_c) begin
          pop_c = 1'b1;
          if (sel_word_c[EOF]) begin
            state_nxt = ST_IDLE;
            last_nxt  = src;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (port2rxfis_flush) begin
      state_nxt = ST_IDLE;
      last_nxt  = last;
      pop_c     = 1'b0;
      load_c    = 1'b0;
      ovr_c     = 1'b0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state    <= ST_IDLE;
      src      <= SRC_DATA;
      last     <= SRC_NDR;
      cnt      <= '0;
      frames   <= '0;
      overruns <= '0;
      ferr     <= 1'b0;
    end else begin
      state <= state_nxt;
      src   <= src_nxt;
      last  <= last_nxt;
      cnt   <= cnt_nxt;
      if (done_c)
        frames <= frames + FRM_W'(1);
      if (ovr_c && overruns != '1)
        overruns <= overruns + OVR_W'(1);
      // Sticky per-frame error, covering every word loaded for the frame.
      if (port2rxfis_flush)
        ferr <= 1'b0;
      else if (load_c)
        ferr <= (ferr && !done_c) || ld_word_c.word[ERR];
      else if (done_c)
        ferr <= 1'b0;
    end
  end

  rxfis_oreg u_oreg (
    .clk      (sys_clk),
    .rst      (sys_rst),
    .flush    (port2rxfis_flush),
    .load     (load_c),
    .ld_data  (ld_word_c),
    .ready    (rxdma2rxfis_ready),
    .valid    (oreg_valid),
    .data     (oreg_q),
    .accept_c (accept_c)
  );

  assign rxfis2rxll_rd_en      = pop_c && (src == SRC_DATA) && !sys_rst;
  assign rxfis2ififo_ndr_rd_en = pop_c && (src == SRC_NDR) && !sys_rst;
  assign rxfis2rxdma_do        = oreg_q.word;
  assign rxfis2rxdma_src       = oreg_q.src;
  assign rxfis2rxdma_valid     = oreg_valid;
  assign rxfis2port_done       = done_c;
  assign rxfis2port_err        = done_c && (ferr || oreg_q.word[ERR]);
  assign rxfis2dbg             = {5'd0, 3'(state), overruns, frames};

endmodule
